ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Pipelined main-control unit for the 5-stage RV32 core. Decodes the ID-stage opcode into a control word and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Generates the load-use stall and applies branch/jump flush bubbles.
- Latches a sticky halted flag when a HALT retires.

Parameters:
- REG_AW, 5, register-index width (rs1/rs2/rd)
- EN_HAZARD, 1, 1 enables load-use stall detection; 0 ties stall to 0

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  instruction[6:0]
- id_rs1  in  REG_AW  source register 1
- id_rs2  in  REG_AW  source register 2
- id_rd  in  REG_AW  destination register
- flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID
- stall  out  1  freeze PC and IF/ID (combinational)
- illegal  out  1  one-cycle pulse: valid ID opcode not in decode table, not stalled
- ex_valid  out  1  EX stage valid
- ex_alusrc  out  1  ALUSrc for EX
- ex_aluop  out  2  ALUOp for EX
- ex_branch  out  1  Branch for EX
- ex_jalr  out  1  Jalr for EX
- ex_rd  out  REG_AW  EX destination
- mem_valid  out  1  MEM stage valid
- mem_read  out  1  MemRead
- mem_write  out  1  MemWrite
- wb_valid  out  1  WB stage valid
- wb_regwrite  out  1  RegWrite, gated by wb_valid
- wb_memtoreg  out  1  MemtoReg
- wb_rwsel  out  1  RWSel
- wb_rd  out  REG_AW  WB destination
- halted  out  1  sticky; HALT has retired

Behaviour:
- Decode (combinational, ID). Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, HALT 1111111.
  - ALUSrc = LW|SW|I|JALR
  - MemtoReg = MemRead = LW
  - RegWrite = R|LW|I|JAL|JALR
  - RWSel = JAL|JALR
  - MemWrite = SW
  - ALUOp[0] = BR|JAL|HALT
  - ALUOp[1] = R|I|JAL|JALR|HALT
  - Branch = BR|JAL|HALT
  - Jalr = JALR
  - Any other opcode: all-zero control word (NOP) plus illegal pulse.
- Pipeline: control fields appear on ex_* 1 cycle after ID capture, on mem_* after 2 cycles, and on wb_* after 3 cycles. Each stage register updates every cycle; there is no back-pressure beyond stall.
- Bubble: valid=0 and every control bit 0; rd is don't-care but is driven 0.
- Load-use stall: stall = EN_HAZARD & id_valid & ex_valid & ex_memread(internal) & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - While stalled, a bubble enters EX; mem/wb advance normally.
  - Stall lasts exactly 1 cycle per hazard.
- Flush: the ID→EX register loads a bubble. flush has priority over stall, and stall is forced to 0 when flush=1. flush does not affect EX/MEM/WB.
- illegal: asserted only when id_valid & !stall & !flush & opcode unknown.
- HALT: decoded as above, sets an internal halt bit that travels with the word.
  - When a valid HALT is in WB, halted is set on the next edge.
  - Once halted=1, all subsequent stage inputs are forced to bubbles, stall=0, illegal=0.
  - Only rst_n clears halted.
  - A HALT killed by flush never sets halted.
- Reset (async, rst_n=0): all stage registers become bubbles; ex_/mem_/wb_ outputs=0; halted=0. stall and illegal are combinational and read 0 while reset holds.
- Reset asserted mid-stall or mid-drain: state is discarded immediately with no partial retire. After release, the first valid ID instruction reaches EX on the following edge.

Test Plan:
- Reset: rst_n=0 mid-stream with valid words in all stages -> all outputs 0 within the same cycle, halted=0.
- Latency: R-type (0110011, rd=5) issued at cycle 0 -> ex_valid at 1 with aluop=10, alusrc=0; mem_read=mem_write=0 at 2; wb_regwrite=1, wb_rd=5 at 3.
- Load-use: LW rd=3 then ADD rs1=3 -> stall=1 for one cycle, EX holds a bubble, ADD reaches EX one cycle late. Repeat with rd=0 -> no stall. Repeat with EN_HAZARD=0 -> no stall.
- Flush priority: flush=1 on the same cycle as a load-use hazard -> stall=0, EX receives a bubble, the earlier LW still completes with wb_memtoreg=1.
- Illegal/HALT: opcode 0000000 valid -> illegal pulse, NOP through the pipe. HALT issued -> halted=1 four edges later, and later instructions produce only bubbles. A flushed HALT -> halted stays 0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Main-control unit for the 5-stage RV32 core: decodes the ID opcode, carries the
// control word through ID/EX, EX/MEM and MEM/WB, detects load-use stalls and flushes, latches HALT.
module ctrl_pipe #(
  parameter int unsigned REG_AW    = 5,
  parameter bit          EN_HAZARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              illegal,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic              ex_branch,
  output logic              ex_jalr,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              wb_rwsel,
  output logic [REG_AW-1:0] wb_rd,
  output logic              halted
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  logic w_r, w_i, w_lw, w_sw, w_br, w_jal, w_jalr, w_halt, w_known;
  logic w_alusrc, w_memtoreg, w_memread, w_regwrite, w_rwsel, w_memwrite;
  logic w_branch, w_jalr_c;
  logic [1:0] w_aluop;
  logic w_hazard, w_issue;

  logic              r_ex_valid, r_ex_alusrc, r_ex_branch, r_ex_jalr;
  logic [1:0]        r_ex_aluop;
  logic              r_ex_memread, r_ex_memwrite, r_ex_regwrite, r_ex_memtoreg, r_ex_rwsel, r_ex_halt;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_valid, r_mem_read, r_mem_write, r_mem_regwrite, r_mem_memtoreg, r_mem_rwsel, r_mem_halt;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_wb_valid, r_wb_regwrite, r_wb_memtoreg, r_wb_rwsel, r_wb_halt;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_halted;

  // Opcode decode; unknown opcodes fall out as an all-zero control word.
  assign w_r     = (id_opcode == OP_R);
  assign w_i     = (id_opcode == OP_I);
  assign w_lw    = (id_opcode == OP_LW);
  assign w_sw    = (id_opcode == OP_SW);
  assign w_br    = (id_opcode == OP_BR);
  assign w_jal   = (id_opcode == OP_JAL);
  assign w_jalr  = (id_opcode == OP_JALR);
  assign w_halt  = (id_opcode == OP_HALT);
  assign w_known = w_r | w_i | w_lw | w_sw | w_br | w_jal | w_jalr | w_halt;

  assign w_alusrc   = w_lw | w_sw | w_i | w_jalr;
  assign w_memtoreg = w_lw;
  assign w_memread  = w_lw;
  assign w_regwrite = w_r | w_lw | w_i | w_jal | w_jalr;
  assign w_rwsel    = w_jal | w_jalr;
  assign w_memwrite = w_sw;
  assign w_aluop    = {w_r | w_i | w_jal | w_jalr | w_halt, w_br | w_jal | w_halt};
  assign w_branch   = w_br | w_jal | w_halt;
  assign w_jalr_c   = w_jalr;

  // Load in EX whose destination feeds the instruction now in ID.
  assign w_hazard = r_ex_valid & r_ex_memread & (r_ex_rd != '0) &
                    ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
  assign stall    = EN_HAZARD & id_valid & ~flush & ~r_halted & w_hazard;
  assign illegal  = rst_n & id_valid & ~stall & ~flush & ~r_halted & ~w_known;
  assign w_issue  = id_valid & ~flush & ~stall & ~r_halted;

  // ID/EX: stall, flush and halted all inject a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !w_issue) begin
      r_ex_valid    <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_aluop    <= 2'b00;
      r_ex_branch   <= 1'b0;
      r_ex_jalr     <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_rwsel    <= 1'b0;
      r_ex_halt     <= 1'b0;
      r_ex_rd       <= '0;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_alusrc   <= w_alusrc;
      r_ex_aluop    <= w_aluop;
      r_ex_branch   <= w_branch;
      r_ex_jalr     <= w_jalr_c;
      r_ex_memread  <= w_memread;
      r_ex_memwrite <= w_memwrite;
      r_ex_regwrite <= w_regwrite;
      r_ex_memtoreg <= w_memtoreg;
      r_ex_rwsel    <= w_rwsel;
      r_ex_halt     <= w_halt;
      r_ex_rd       <= id_rd;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; once halted they only take bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || r_halted) begin
      r_mem_valid    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_rwsel    <= 1'b0;
      r_mem_halt     <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rwsel     <= 1'b0;
      r_wb_halt      <= 1'b0;
      r_wb_rd        <= '0;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_read     <= r_ex_memread;
      r_mem_write    <= r_ex_memwrite;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_rwsel    <= r_ex_rwsel;
      r_mem_halt     <= r_ex_halt;
      r_mem_rd       <= r_ex_rd;
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_rwsel     <= r_mem_rwsel;
      r_wb_halt      <= r_mem_halt;
      r_wb_rd        <= r_mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_halted <= 1'b0;
    else        r_halted <= r_halted | (r_wb_valid & r_wb_halt);
  end

  assign ex_valid    = r_ex_valid;
  assign ex_alusrc   = r_ex_alusrc;
  assign ex_aluop    = r_ex_aluop;
  assign ex_branch   = r_ex_branch;
  assign ex_jalr     = r_ex_jalr;
  assign ex_rd       = r_ex_rd;
  assign mem_valid   = r_mem_valid;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign wb_valid    = r_wb_valid;
  assign wb_regwrite = r_wb_valid & r_wb_regwrite;
  assign wb_memtoreg = r_wb_memtoreg;
  assign wb_rwsel    = r_wb_rwsel;
  assign wb_rd       = r_wb_rd;
  assign halted      = r_halted;

endmodule
